// File: rtl/airlock_pkg.sv
// Shared types, state encodings and default timing for the two-door airlock controller.
package airlock_pkg;

    localparam logic [2:0] ENC_PRESS      = 3'd0;
    localparam logic [2:0] ENC_INNER_OPEN = 3'd1;
    localparam logic [2:0] ENC_PUMP_DN    = 3'd2;
    localparam logic [2:0] ENC_VAC        = 3'd3;
    localparam logic [2:0] ENC_OUTER_OPEN = 3'd4;
    localparam logic [2:0] ENC_PUMP_UP    = 3'd5;

    typedef enum logic [2:0] {
        ST_PRESS      = ENC_PRESS,
        ST_INNER_OPEN = ENC_INNER_OPEN,
        ST_PUMP_DN    = ENC_PUMP_DN,
        ST_VAC        = ENC_VAC,
        ST_OUTER_OPEN = ENC_OUTER_OPEN,
        ST_PUMP_UP    = ENC_PUMP_UP
    } airlock_state_t;

    localparam int PUMP_CYCLES_DEF      = 8;
    localparam int AUTOCLOSE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF            = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/airlock_if.sv
// Request pulses from the user-input stage and door/pump status back to the board.
interface airlock_if;
    logic inner_req;
    logic outer_req;
    logic evac_req;
    logic press_req;
    logic inner_open;
    logic outer_open;
    logic pumping;
    logic pressurized;
    logic reject;

    modport master (
        output inner_req, outer_req, evac_req, press_req,
        input  inner_open, outer_open, pumping, pressurized, reject
    );

    modport slave (
        input  inner_req, outer_req, evac_req, press_req,
        output inner_open, outer_open, pumping, pressurized, reject
    );
endinterface

// File: rtl/airlock_timer.sv
// Loadable down-counter: load wins over en, count saturates at zero.
module airlock_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/airlock_controller.sv
// Two-door airlock sequencer with interlocks and registered outputs.
// Optional door auto-close is enabled by defining AIRLOCK_AUTOCLOSE_EN.
module airlock_controller
    import airlock_pkg::*;
#(
    parameter int PUMP_CYCLES      = PUMP_CYCLES_DEF,
    parameter int AUTOCLOSE_CYCLES = AUTOCLOSE_CYCLES_DEF,
    parameter int CNT_W            = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    airlock_if.slave bus
);

    localparam logic [CNT_W-1:0] PUMP_LOAD = CNT_W'(PUMP_CYCLES - 1);
    localparam int               TMR_MAX   = max_int(PUMP_CYCLES, AUTOCLOSE_CYCLES);
`ifdef AIRLOCK_AUTOCLOSE_EN
    localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(AUTOCLOSE_CYCLES - 1);
`endif

    airlock_state_t state_q, state_d;
    logic inner_open_q, inner_open_d;
    logic outer_open_q, outer_open_d;
    logic pumping_q, pumping_d;
    logic pressurized_q, pressurized_d;
    logic reject_q, reject_d;

    logic [3:0]       req_vec;
    logic [3:0]       acc_vec;
    logic             tmr_load;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_load_val;
    logic [CNT_W-1:0] tmr_cnt;
    logic             tmr_zero;

    // Bit order {press, evac, outer, inner}; acc_vec marks the single accepted pulse.
    assign req_vec = {bus.press_req, bus.evac_req, bus.outer_req, bus.inner_req};

    airlock_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .cnt      (tmr_cnt),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        acc_vec      = '0;
        tmr_load     = 1'b0;
        tmr_load_val = PUMP_LOAD;
        tmr_en       = 1'b0;
        unique case (state_q)
            ST_PRESS: begin
                if (bus.evac_req) begin
                    state_d  = ST_PUMP_DN;
                    acc_vec  = 4'b0100;
                    tmr_load = 1'b1;
                end else if (bus.inner_req) begin
                    state_d = ST_INNER_OPEN;
                    acc_vec = 4'b0001;
`ifdef AIRLOCK_AUTOCLOSE_EN
                    tmr_load     = 1'b1;
                    tmr_load_val = CLOSE_LOAD;
`endif
                end
            end
            ST_INNER_OPEN: begin
                if (bus.inner_req) begin
                    state_d = ST_PRESS;
                    acc_vec = 4'b0001;
                end
`ifdef AIRLOCK_AUTOCLOSE_EN
                else if (tmr_zero) begin
                    state_d = ST_PRESS;
                end else begin
                    tmr_en = 1'b1;
                    if (|req_vec) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = CLOSE_LOAD;
                    end
                end
`endif
            end
            ST_PUMP_DN: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_VAC;
                end
            end
            ST_VAC: begin
                if (bus.press_req) begin
                    state_d  = ST_PUMP_UP;
                    acc_vec  = 4'b1000;
                    tmr_load = 1'b1;
                end else if (bus.outer_req) begin
                    state_d = ST_OUTER_OPEN;
                    acc_vec = 4'b0010;
`ifdef AIRLOCK_AUTOCLOSE_EN
                    tmr_load     = 1'b1;
                    tmr_load_val = CLOSE_LOAD;
`endif
                end
            end
            ST_OUTER_OPEN: begin
                if (bus.outer_req) begin
                    state_d = ST_VAC;
                    acc_vec = 4'b0010;
                end
`ifdef AIRLOCK_AUTOCLOSE_EN
                else if (tmr_zero) begin
                    state_d = ST_VAC;
                end else begin
                    tmr_en = 1'b1;
                    if (|req_vec) begin
                        tmr_load     = 1'b1;
                        tmr_load_val = CLOSE_LOAD;
                    end
                end
`endif
            end
            ST_PUMP_UP: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_PRESS;
                end
            end
            default: state_d = ST_PRESS;
        endcase

        // Outputs are decoded from the next state so they land on the same edge as it.
        inner_open_d  = (state_d == ST_INNER_OPEN);
        outer_open_d  = (state_d == ST_OUTER_OPEN);
        pumping_d     = (state_d == ST_PUMP_DN) || (state_d == ST_PUMP_UP);
        pressurized_d = (state_d == ST_PRESS) || (state_d == ST_INNER_OPEN) ||
                        (state_d == ST_PUMP_DN);
        reject_d      = |(req_vec & ~acc_vec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PRESS;
            inner_open_q  <= 1'b0;
            outer_open_q  <= 1'b0;
            pumping_q     <= 1'b0;
            pressurized_q <= 1'b1;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            inner_open_q  <= inner_open_d;
            outer_open_q  <= outer_open_d;
            pumping_q     <= pumping_d;
            pressurized_q <= pressurized_d;
            reject_q      <= reject_d;
        end
    end

    assign bus.inner_open  = inner_open_q;
    assign bus.outer_open  = outer_open_q;
    assign bus.pumping     = pumping_q;
    assign bus.pressurized = pressurized_q;
    assign bus.reject      = reject_q;

    a_doors_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(inner_open_q && outer_open_q));
    a_pump_doors_shut: assert property (@(posedge clk) disable iff (!rst_n)
        pumping_q |-> (!inner_open_q && !outer_open_q));
    a_timer_range: assert property (@(posedge clk) disable iff (!rst_n)
        int'(tmr_cnt) <= TMR_MAX - 1);

endmodule

// File: tb/tb_airlock_controller.sv
// Directed bench for airlock_controller; define AIRLOCK_AUTOCLOSE_EN to add the auto-close vectors.
module tb_airlock_controller;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    airlock_if bus ();

    airlock_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic io, input logic oo,
                           input logic pu, input logic pr, input logic rj);
        chk({tag, ".inner_open"},  32'(bus.inner_open),  32'(io));
        chk({tag, ".outer_open"},  32'(bus.outer_open),  32'(oo));
        chk({tag, ".pumping"},     32'(bus.pumping),     32'(pu));
        chk({tag, ".pressurized"}, 32'(bus.pressurized), 32'(pr));
        chk({tag, ".reject"},      32'(bus.reject),      32'(rj));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // v = {press, evac, outer, inner}, held for exactly one sampling edge.
    task automatic pulse(input logic [3:0] v);
        {bus.press_req, bus.evac_req, bus.outer_req, bus.inner_req} = v;
        tick();
        {bus.press_req, bus.evac_req, bus.outer_req, bus.inner_req} = 4'b0000;
    endtask

    // Counts visible pumping cycles starting with the current one.
    task automatic wait_pump(output int n);
        n = 0;
        while (bus.pumping === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    int n;
    int m;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        {bus.press_req, bus.evac_req, bus.outer_req, bus.inner_req} = 4'b0000;

        // 1: reset and idle
        repeat (3) tick();
        chk_out("in_reset", 0, 0, 0, 1, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) tick();
        chk_out("idle", 0, 0, 0, 1, 0);

        // 2: full cycle through the lock
        pulse(4'b0001);
        chk_out("inner_open", 1, 0, 0, 1, 0);
        pulse(4'b0001);
        chk_out("inner_close", 0, 0, 0, 1, 0);
        pulse(4'b0100);
        chk_out("pump_dn_start", 0, 0, 1, 1, 0);
        wait_pump(n);
        chk("pump_dn_len", 32'(n), 32'd8);
        chk_out("vac", 0, 0, 0, 0, 0);
        pulse(4'b0010);
        chk_out("outer_open", 0, 1, 0, 0, 0);
        pulse(4'b0010);
        chk_out("outer_close", 0, 0, 0, 0, 0);
        pulse(4'b0001);
        chk_out("vac_inner_rej", 0, 0, 0, 0, 1);
        pulse(4'b1000);
        chk_out("pump_up_start", 0, 0, 1, 0, 0);
        wait_pump(n);
        chk("pump_up_len", 32'(n), 32'd8);
        chk_out("press_again", 0, 0, 0, 1, 0);

        // 3: refused requests
        pulse(4'b0010);
        chk_out("press_outer_rej", 0, 0, 0, 1, 1);
        tick();
        chk("rej_one_cycle", 32'(bus.reject), 32'd0);
        pulse(4'b1000);
        chk_out("press_press_rej", 0, 0, 0, 1, 1);
        tick();
        pulse(4'b0100);
        tick();
        tick();
        pulse(4'b0001);
        chk_out("pump_inner_rej", 0, 0, 1, 1, 1);
        wait_pump(m);
        chk("pump_rest_len", 32'(m), 32'd5);
        chk_out("vac_after_rej", 0, 0, 0, 0, 0);
        pulse(4'b1000);
        wait_pump(n);
        chk("pump_up_len2", 32'(n), 32'd8);

        // 4: simultaneous inner+evac, pump wins
        pulse(4'b0101);
        chk_out("simul_pump_wins", 0, 0, 1, 1, 1);
        wait_pump(n);
        chk("simul_pump_len", 32'(n), 32'd8);
        pulse(4'b1010);
        chk_out("vac_simul_press_wins", 0, 0, 1, 0, 1);
        wait_pump(n);
        chk("vac_simul_len", 32'(n), 32'd8);
        chk_out("press_after_simul", 0, 0, 0, 1, 0);

        // 5: asynchronous reset at pump cycle 4
        pulse(4'b0100);
        tick();
        tick();
        tick();
        chk("pump_cycle4", 32'(bus.pumping), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0, 1, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse(4'b0001);
        chk_out("post_reset_inner", 1, 0, 0, 1, 0);
        pulse(4'b0001);
        chk_out("post_reset_close", 0, 0, 0, 1, 0);

`ifdef AIRLOCK_AUTOCLOSE_EN
        // 6: door auto-close and reload on a refused request
        pulse(4'b0001);
        n = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (bus.inner_open === 1'b1) n++;
        end
        chk("ac_open_15", 32'(n), 32'd15);
        tick();
        chk_out("ac_closed_16", 0, 0, 0, 1, 0);
        pulse(4'b0001);
        repeat (9) tick();
        pulse(4'b0100);
        chk_out("ac_evac_rej", 1, 0, 0, 1, 1);
        n = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (bus.inner_open === 1'b1) n++;
        end
        chk("ac_reload_15", 32'(n), 32'd15);
        tick();
        chk_out("ac_reload_closed", 0, 0, 0, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
